stim_pattern_gen: RTL and testbench



---
 rtl/stim_pattern_gen_if.sv | 33 +++
 rtl/stim_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_stim_pattern_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stim_pattern_gen_if.sv
// Bundles the pattern-load, playback-control and output-stream signals of stim_pattern_gen.
// master is the generator side; slave is the side that loads, configures and consumes.
interface stim_pattern_gen_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned DLY_W = 16
);
  logic             load;
  logic [PTR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic             loop;
  logic [PTR_W-1:0] len;
  logic [DLY_W-1:0] delay;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [PTR_W-1:0] ptr;

  modport master (
    input  load, wr_addr, wr_data, start, stop, mode, loop, len, delay, out_ready,
    output out_valid, out_data, busy, done, ptr
  );

  modport slave (
    output load, wr_addr, wr_data, start, stop, mode, loop, len, delay, out_ready,
    input  out_valid, out_data, busy, done, ptr
  );
endinterface

// File: rtl/stim_pattern_gen.sv
// Pattern generator: a DEPTH x WIDTH memory loaded word-by-word and played out over a
// valid/ready stream with a programmable inter-word gap, per-word transform and optional loop.
module stim_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned DLY_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stim_pattern_gen_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEmit = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [PTR_W:0] DepthW = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             stop_q, stop_d;
  logic [1:0]       mode_q;
  logic             loop_q;
  logic [PTR_W-1:0] len_q;
  logic [DLY_W-1:0] delay_q;

  logic cfg_take;
  logic bad_len;
  logic last;

  assign cfg_take = (state_q == StIdle) && bus.start;
  assign bad_len  = (bus.len == '0) || ({1'b0, bus.len} > DepthW);
  assign last     = (ptr_q == len_q - PTR_W'(1));

  function automatic logic [WIDTH-1:0] xform(input logic [1:0] m, input logic [PTR_W-1:0] p);
    case (m)
      2'b00:   return mem[p];
      2'b01:   return mem[p] >> SHIFT;
      2'b10:   return ~mem[p];
      default: return mem[0] + WIDTH'(p);
    endcase
  endfunction

  // Memory is deliberately left out of reset so a replay after reset sees the old pattern.
  always_ff @(posedge clk) begin
    if (bus.load && (state_q == StIdle) && ({1'b0, bus.wr_addr} < DepthW)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    stop_d  = stop_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bad_len) begin
            done_d = 1'b1;
          end else begin
            ptr_d   = '0;
            stop_d  = 1'b0;
            data_d  = xform(bus.mode, '0);
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (bus.stop) stop_d = 1'b1;
        if (bus.out_ready) begin
          if (stop_q || bus.stop) begin
            stop_d  = 1'b0;
            state_d = StIdle;
          end else if (last && !loop_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            ptr_d = last ? '0 : ptr_q + PTR_W'(1);
            if (delay_q != '0) begin
              cnt_d   = delay_q - DLY_W'(1);
              state_d = StWait;
            end else begin
              data_d = xform(mode_q, ptr_d);
            end
          end
        end
      end
      StWait: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          data_d  = xform(mode_q, ptr_q);
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      mode_q  <= '0;
      loop_q  <= 1'b0;
      len_q   <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
      if (cfg_take) begin
        mode_q  <= bus.mode;
        loop_q  <= bus.loop;
        len_q   <= bus.len;
        delay_q <= bus.delay;
      end
    end
  end

  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Randomised and directed bench for stim_pattern_gen against a word-sequence reference model.
module tb_stim_pattern_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] mem_m [5];

  always #5 clk = ~clk;

  stim_pattern_gen_if #(.WIDTH(8), .PTR_W(3), .DLY_W(16)) bus ();

  stim_pattern_gen #(
    .WIDTH(8), .DEPTH(5), .PTR_W(3), .SHIFT(2), .DLY_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_word(input logic [1:0] m, input int i);
    case (m)
      2'd0:    return mem_m[i];
      2'd1:    return mem_m[i] >> 2;
      2'd2:    return ~mem_m[i];
      default: return mem_m[0] + 8'(i);
    endcase
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Idle-only load; the model mirrors the write only for in-range addresses.
  task automatic load_word(input logic [2:0] a, input logic [7:0] d);
    bus.load = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.load = 1'b0;
    if (a < 3'd5) mem_m[a] = d;
  endtask

  task automatic play(input logic [1:0] m, input logic [2:0] l, input logic [15:0] d,
                      input int pct, input int hold, input logic with_stop);
    int cyc, idx, exp_at;
    bit waiting;
    bus.mode = m; bus.loop = 1'b0; bus.len = l; bus.delay = d;
    bus.start = 1'b1; bus.stop = with_stop; bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    // Scramble config after start; playback must use the latched values.
    bus.mode = 2'($urandom); bus.loop = 1'($urandom); bus.len = 3'($urandom);
    bus.delay = 16'($urandom_range(0, 9));
    cyc = 0; idx = 0; exp_at = 0; waiting = 1'b1;
    while (idx < int'(l) && cyc < 500) begin
      bus.out_ready = (cyc >= hold) && ($urandom_range(0, 99) < pct);
      check("done_early", 32'(bus.done), 32'(0));
      if (bus.out_valid) begin
        if (waiting) begin
          check("valid_at", cyc, exp_at);
          waiting = 1'b0;
        end
        check("data", 32'(bus.out_data), 32'(exp_word(m, idx)));
        check("ptr", 32'(bus.ptr), idx);
        if (bus.out_ready) begin
          idx++;
          waiting = 1'b1;
          exp_at = cyc + int'(d) + 1;
        end
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("timeout", idx, 32'(l));
    check("done_pulse", 32'(bus.done), 32'(1));
    check("valid_in_done", 32'(bus.out_valid), 32'(0));
    tick();
    check("done_width", 32'(bus.done), 32'(0));
    check("busy_after", 32'(bus.busy), 32'(0));
    if (idx != int'(l)) apply_reset();
  endtask

  task automatic bad_start(input logic [2:0] l);
    bus.len = l; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("bad_done", 32'(bus.done), 32'(1));
    check("bad_busy", 32'(bus.busy), 32'(0));
    check("bad_valid", 32'(bus.out_valid), 32'(0));
    tick();
    check("bad_done_end", 32'(bus.done), 32'(0));
    check("bad_valid2", 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.mode = '0; bus.loop = 1'b0; bus.len = '0; bus.delay = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'(0));
    check("rst_data", 32'(bus.out_data), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_ptr", 32'(bus.ptr), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) load_word(3'(i), 8'(8'h11 * (i + 1)));
    play(2'd0, 3'd5, 16'd0, 100, 0, 1'b0);
    play(2'd1, 3'd5, 16'd3, 100, 0, 1'b0);
    play(2'd2, 3'd2, 16'd0, 100, 4, 1'b0);

    // Loop with ramp, then stop while the 00 word is held.
    load_word(3'd0, 8'hFE);
    bus.mode = 2'd3; bus.loop = 1'b1; bus.len = 3'd3; bus.delay = 16'd0;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("loop_valid", 32'(bus.out_valid), 32'(1));
      check("loop_data", 32'(bus.out_data), 32'(8'(8'hFE + 8'(k % 3))));
      tick();
    end
    bus.out_ready = 1'b0;
    check("hold_data", 32'(bus.out_data), 32'(8'h00));
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("stop_valid", 32'(bus.out_valid), 32'(1));
      check("stop_data", 32'(bus.out_data), 32'(8'h00));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stop_idle", 32'(bus.busy), 32'(0));
    check("stop_nodone", 32'(bus.done), 32'(0));
    check("stop_valid_off", 32'(bus.out_valid), 32'(0));
    tick();
    check("stop_nodone2", 32'(bus.done), 32'(0));
    load_word(3'd0, 8'h11);

    // Load while busy and load out of range must both be dropped.
    bus.mode = 2'd0; bus.loop = 1'b0; bus.len = 3'd5; bus.delay = 16'd4;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("busy_pre", 32'(bus.busy), 32'(1));
    bus.load = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'hAA;
    tick();
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check("drain", 32'(bus.busy), 32'(0));
    bus.out_ready = 1'b0;
    load_word(3'd6, 8'h99);
    play(2'd0, 3'd5, 16'd0, 100, 0, 1'b0);
    bad_start(3'd0);
    bad_start(3'd6);

    // Asynchronous reset in WAIT, then replay from retained memory.
    bus.mode = 2'd0; bus.len = 3'd5; bus.delay = 16'd5; bus.start = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    check("wait_busy", 32'(bus.busy), 32'(1));
    check("wait_ptr", 32'(bus.ptr), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'(0));
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_ptr", 32'(bus.ptr), 32'(0));
    check("arst_done", 32'(bus.done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    play(2'd0, 3'd5, 16'd0, 100, 0, 1'b0);

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int w = 0; w < 3; w++) load_word(3'($urandom_range(0, 7)), 8'($urandom));
      end
      play(2'($urandom), 3'($urandom_range(1, 5)), 16'($urandom_range(0, 3)),
           $urandom_range(40, 100), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
